rs232in_fifo: RTL and testbench

RS232IN_FIFO -- requirements
Module: rs232in_fifo

---
 rtl/soclib_pkg.sv | 10 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/rs232in_fifo.sv | 51 +++++
 tb/tb_rs232in_fifo.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/soclib_pkg.sv
// Shared SoC peripheral constants: RS232 receive FIFO defaults and its
// register map as seen from the peripheral bus.
package soclib_pkg;
  localparam int RS232IN_DEPTH_LOG2 = 4;
  localparam int RS232IN_THRESHOLD  = 8;

  localparam logic [3:0] RS232IN_REG_DATA   = 4'h0;
  localparam logic [3:0] RS232IN_REG_COUNT  = 4'h4;
  localparam logic [3:0] RS232IN_REG_STATUS = 4'h8;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: storage plus pointers, zero-latency head read,
// registered occupancy flags.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd,
  output logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count_nxt;
  logic                  push, pop;

  // A pop frees the slot the push needs, so a full FIFO still accepts a
  // write when it is read in the same cycle.
  assign pop  = rd & ~empty;
  assign push = wr & (~full | pop);

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CNT_FULL);
    end
  end
endmodule

// File: rtl/rs232in_fifo.sv
// RS232 receive buffer: adapts the receiver's byte strobe to a FIFO and
// adds a sticky overrun flag and a registered fill-level interrupt.
module rs232in_fifo
  import soclib_pkg::*;
#(
  parameter int DEPTH_LOG2 = RS232IN_DEPTH_LOG2,
  parameter int THRESHOLD  = RS232IN_THRESHOLD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rs232in_attention,
  input  logic [7:0]          rs232in_data,
  input  logic                rd,
  input  logic                clr_overrun,
  output logic [7:0]          rd_data,
  output logic [DEPTH_LOG2:0] count,
  output logic                empty,
  output logic                full,
  output logic                overrun,
  output logic                level_irq
);
  localparam logic [DEPTH_LOG2:0] THR = (DEPTH_LOG2+1)'(THRESHOLD);

  logic drop;

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr      (rs232in_attention),
    .wr_data (rs232in_data),
    .rd      (rd),
    .rd_data (rd_data),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

  // Byte is lost only when full and no accepted pop makes room.
  assign drop = rs232in_attention & full & ~(rd & ~empty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      level_irq <= 1'b0;
    end else begin
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
      level_irq <= (count >= THR);
    end
  end
endmodule

// File: tb/tb_rs232in_fifo.sv
// Self-checking bench for rs232in_fifo: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_rs232in_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       att = 1'b0;
  logic [7:0] din = 8'h00;
  logic       rd  = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic       empty, full, overrun, level_irq;

  rs232in_fifo dut (
    .clk(clk), .rst(rst), .rs232in_attention(att), .rs232in_data(din),
    .rd(rd), .clr_overrun(clr), .rd_data(rd_data), .count(count),
    .empty(empty), .full(full), .overrun(overrun), .level_irq(level_irq)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // reference model state
  logic [7:0] q[$];
  logic       m_ov  = 1'b0;
  logic       m_irq = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_ov  = 1'b0;
    m_irq = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(q.size()));
    chk({tag, "_empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, "_full"},  32'(full),  32'(q.size() == 16));
    chk({tag, "_ovr"},   32'(overrun), 32'(m_ov));
    chk({tag, "_irq"},   32'(level_irq), 32'(m_irq));
    if (q.size() != 0) chk({tag, "_rdata"}, 32'(rd_data), 32'(q[0]));
  endtask

  // One clock: drive inputs, advance the model, sample 1 ns after the edge.
  task automatic cycle(input logic a, input logic [7:0] d, input logic r,
                       input logic c, input string tag);
    bit pop_ok, push_ok;
    att = a; din = d; rd = r; clr = c;
    pop_ok  = r && (q.size() > 0);
    push_ok = a && ((q.size() < 16) || pop_ok);
    m_irq = (q.size() >= 8);
    if (a && !push_ok) m_ov = 1'b1;
    else if (c)        m_ov = 1'b0;
    if (pop_ok)  void'(q.pop_front());
    if (push_ok) q.push_back(d);
    @(posedge clk); #1;
    att = 1'b0; rd = 1'b0; clr = 1'b0;
    check_model(tag);
  endtask

  typedef struct {
    logic att; logic [7:0] d; logic rd; logic clr;
    int ecount; logic eempty; logic efull; logic eov; logic [7:0] erd;
  } vec_t;
  vec_t tv[7];

  initial begin
    tv[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h41};
    tv[1] = '{1'b1, 8'h42, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 8'h41};
    tv[2] = '{1'b1, 8'h43, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 8'h41};
    tv[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 8'h42};
    tv[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h43};
    tv[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00};
    tv[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00};

    // reset state while reset is held
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full",  32'(full), 0);
    chk("rst_ovr",   32'(overrun), 0);
    chk("rst_irq",   32'(level_irq), 0);
    rst = 1'b0;
    model_reset();

    // basic push/pop vectors
    for (int i = 0; i < 7; i++) begin
      cycle(tv[i].att, tv[i].d, tv[i].rd, tv[i].clr, "tv");
      chk("tv_count_c", 32'(count), 32'(tv[i].ecount));
      chk("tv_empty_c", 32'(empty), 32'(tv[i].eempty));
      chk("tv_full_c",  32'(full), 32'(tv[i].efull));
      chk("tv_ovr_c",   32'(overrun), 32'(tv[i].eov));
      if (!tv[i].eempty) chk("tv_rdata_c", 32'(rd_data), 32'(tv[i].erd));
    end

    // fill past full: 17 pushes, full after 16th, overrun after 17th
    for (int i = 0; i <= 16; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0, "fill");
      if (i == 14) chk("fill_notfull15", 32'(full), 0);
      if (i == 15) chk("fill_full16", 32'(full), 1);
      if (i == 15) chk("fill_noovr16", 32'(overrun), 0);
    end
    chk("fill_ovr17", 32'(overrun), 1);
    chk("fill_cnt17", 32'(count), 16);

    // push with pop at full: no overrun, count stays 16
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "clrov");
    chk("clr_ovr", 32'(overrun), 0);
    cycle(1'b1, 8'h55, 1'b1, 1'b0, "fullpp");
    chk("fullpp_cnt", 32'(count), 16);
    chk("fullpp_ovr", 32'(overrun), 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("fullpp_last", 32'(rd_data), 32'h55);
      else if (i == 0) chk("fullpp_first", 32'(rd_data), 32'h01);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain");
    end

    // pops on empty, then a push
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "udf");
    cycle(1'b1, 8'h7E, 1'b0, 1'b0, "udf_push");
    chk("udf_cnt", 32'(count), 1);
    chk("udf_rdata", 32'(rd_data), 32'h7E);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "udf_pop");

    // level interrupt threshold
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, "irq_fill");
    cycle(1'b0, 8'h00, 1'b0, 1'b0, "irq_idle7");
    chk("irq_at7", 32'(level_irq), 0);
    cycle(1'b1, 8'hA7, 1'b0, 1'b0, "irq_push8");
    chk("irq_lag8", 32'(level_irq), 0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, "irq_idle8");
    chk("irq_at8", 32'(level_irq), 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "irq_pop");
    chk("irq_lagpop", 32'(level_irq), 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, "irq_idle7b");
    chk("irq_deassert", 32'(level_irq), 0);

    // five entries with overrun set, then asynchronous reset mid-cycle
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, "ar_fill");
    for (int i = 0; i < 11; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "ar_pop");
    chk("ar_pre_cnt", 32'(count), 5);
    chk("ar_pre_ovr", 32'(overrun), 1);
    #3 rst = 1'b1;
    #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_empty", 32'(empty), 1);
    chk("ar_full",  32'(full), 0);
    chk("ar_ovr",   32'(overrun), 0);
    chk("ar_irq",   32'(level_irq), 0);
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    cycle(1'b1, 8'h99, 1'b0, 1'b0, "ar_push");
    chk("ar_rdata", 32'(rd_data), 32'h99);

    // random traffic: fill-biased, drain-biased, then balanced phases
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 300; i++) begin
        logic a, r, c;
        a = ($urandom_range(99) < (ph == 0 ? 75 : ph == 1 ? 25 : 50));
        r = ($urandom_range(99) < (ph == 0 ? 25 : ph == 1 ? 75 : 50));
        c = ($urandom_range(99) < 5);
        cycle(a, 8'($urandom), r, c, "rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
